// File: rtl/cpu_int_pkg.sv
// Shared types and default vectors for the CPU interrupt front end.
// Provides the interrupt source encoding, the arbiter FSM states and
// the default vector addresses.
package cpu_int_pkg;

  typedef enum logic [1:0] {
    SRC_RST = 2'b00,
    SRC_NMI = 2'b01,
    SRC_IRQ = 2'b10,
    SRC_BRK = 2'b11
  } int_src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } arb_state_t;

  localparam logic [15:0] VEC_NMI_DEF = 16'hFFFA;
  localparam logic [15:0] VEC_RST_DEF = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ_DEF = 16'hFFFE;

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Handshake bundle between the interrupt arbiter and the instruction sequencer/decoder.
// master: sequencer side (drives boundary/ack/done strobes, I flag, brk_req).
// slave : arbiter side (drives request, source, vector, B bit, set-I pulse).
interface interrupt_arbiter_if;
  import cpu_int_pkg::*;

  logic       i_flag;
  logic       brk_req;
  logic       instr_boundary;
  logic       int_ack;
  logic       vector_done;
  logic       rti_done;
  logic       int_request;
  int_src_t   int_source;
  logic [15:0] vector_addr;
  logic       b_flag_push;
  logic       set_i_flag;

  modport master (
    output i_flag, brk_req, instr_boundary, int_ack, vector_done, rti_done,
    input  int_request, int_source, vector_addr, b_flag_push, set_i_flag
  );

  modport slave (
    input  i_flag, brk_req, instr_boundary, int_ack, vector_done, rti_done,
    output int_request, int_source, vector_addr, b_flag_push, set_i_flag
  );

endinterface

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for an asynchronous active-low pin.
// Ports: clk, nrst, en (clock qualifier, holds when low), pinIn, pinSync.
// Resets to 1 so the pin reads inactive until real samples arrive.
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic pinIn,
  output logic pinSync
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= '1;
    end else if (en) begin
      chain <= {chain[SYNC_STAGES-2:0], pinIn};
    end
  end

  assign pinSync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/interrupt_arbiter.sv
// Interrupt front end: synchronises NMI/IRQ pins, edge-detects NMI, arbitrates
// RESET > NMI > IRQ > BRK at instruction boundaries and runs the request/ack handshake.
// Ports: clk, nrst, enableFFs, nmi_n, irq_n, seq (sequencer handshake), nmi_pending, nmi_running.
module interrupt_arbiter
  import cpu_int_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] VEC_NMI     = VEC_NMI_DEF,
  parameter logic [15:0] VEC_RST     = VEC_RST_DEF,
  parameter logic [15:0] VEC_IRQ     = VEC_IRQ_DEF
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 enableFFs,
  input  logic                 nmi_n,
  input  logic                 irq_n,
  interrupt_arbiter_if.slave   seq,
  output logic                 nmi_pending,
  output logic                 nmi_running
);

  logic       nmiSync, irqSync, nmiSyncPrev;
  logic       nmiEdge, irqAct;
  arb_state_t state, stateNxt;
  int_src_t   src, srcNxt;
  logic       bFlag, bFlagNxt;
  logic       rstPending, rstPendingNxt;
  logic       brkPending, brkPendingNxt;
  logic       nmiPendingNxt, nmiRunningNxt;
  logic       setI;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_nmiSync (
    .clk(clk), .nrst(nrst), .en(enableFFs), .pinIn(nmi_n), .pinSync(nmiSync)
  );

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irqSync (
    .clk(clk), .nrst(nrst), .en(enableFFs), .pinIn(irq_n), .pinSync(irqSync)
  );

  // Falling edge of the synchronised NMI pin.
  assign nmiEdge = nmiSyncPrev & ~nmiSync;
  // IRQ is level sensitive and never latched.
  assign irqAct  = ~irqSync & ~seq.i_flag;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nmiSyncPrev <= 1'b1;
      state       <= ST_IDLE;
      src         <= SRC_RST;
      bFlag       <= 1'b0;
      rstPending  <= 1'b1;
      brkPending  <= 1'b0;
      nmi_pending <= 1'b0;
      nmi_running <= 1'b0;
    end else if (enableFFs) begin
      nmiSyncPrev <= nmiSync;
      state       <= stateNxt;
      src         <= srcNxt;
      bFlag       <= bFlagNxt;
      rstPending  <= rstPendingNxt;
      brkPending  <= brkPendingNxt;
      nmi_pending <= nmiPendingNxt;
      nmi_running <= nmiRunningNxt;
    end
  end

  always_comb begin
    stateNxt      = state;
    srcNxt        = src;
    bFlagNxt      = bFlag;
    rstPendingNxt = rstPending;
    brkPendingNxt = brkPending | seq.brk_req;
    nmiPendingNxt = nmi_pending | nmiEdge;
    nmiRunningNxt = nmi_running & ~seq.rti_done;
    setI          = 1'b0;

    case (state)
      ST_IDLE: begin
        // Reset sequence does not wait for an instruction boundary.
        if (rstPending) begin
          stateNxt = ST_REQ;
          srcNxt   = SRC_RST;
          bFlagNxt = 1'b0;
        end else if (seq.instr_boundary) begin
          if (nmi_pending) begin
            stateNxt = ST_REQ;
            srcNxt   = SRC_NMI;
            bFlagNxt = 1'b0;
          end else if (irqAct) begin
            stateNxt = ST_REQ;
            srcNxt   = SRC_IRQ;
            bFlagNxt = 1'b0;
          end else if (brkPending) begin
            stateNxt = ST_REQ;
            srcNxt   = SRC_BRK;
            bFlagNxt = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (seq.int_ack) begin
          stateNxt = ST_SERVICE;
          if (src == SRC_NMI) begin
            // A fresh edge arriving with the ack keeps the request alive.
            nmiPendingNxt = nmiEdge;
            nmiRunningNxt = 1'b1;
            // bFlag on an NMI source means it hijacked a BRK.
            if (bFlag) brkPendingNxt = seq.brk_req;
          end else if (src == SRC_BRK) begin
            brkPendingNxt = seq.brk_req;
          end
        end else if (nmi_pending && (src == SRC_IRQ || src == SRC_BRK)) begin
          srcNxt = SRC_NMI;
        end
      end

      ST_SERVICE: begin
        if (seq.vector_done) begin
          setI     = 1'b1;
          stateNxt = ST_IDLE;
          if (src == SRC_RST) rstPendingNxt = 1'b0;
        end
      end

      default: stateNxt = ST_IDLE;
    endcase
  end

  always_comb begin
    case (src)
      SRC_RST: seq.vector_addr = VEC_RST;
      SRC_NMI: seq.vector_addr = VEC_NMI;
      default: seq.vector_addr = VEC_IRQ;
    endcase
  end

  assign seq.int_request = (state == ST_REQ);
  assign seq.int_source  = src;
  assign seq.b_flag_push = bFlag;
  // Qualified so the pulse only shows on a cycle where the transition is taken.
  assign seq.set_i_flag  = setI & enableFFs;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed self-checking bench for interrupt_arbiter.
// Drives inputs 1ns after the rising edge and samples outputs in the same window.
// Covers reset, NMI, masked/unmasked IRQ, BRK hijack, coincident NMI/ack, enable gating.
module tb_interrupt_arbiter;

  logic clk = 1'b0;
  logic nrst;
  logic enableFFs;
  logic nmi_n;
  logic irq_n;
  logic nmi_pending;
  logic nmi_running;

  int nChecks = 0;
  int nFails  = 0;

  interrupt_arbiter_if ia ();

  interrupt_arbiter dut (
    .clk        (clk),
    .nrst       (nrst),
    .enableFFs  (enableFFs),
    .nmi_n      (nmi_n),
    .irq_n      (irq_n),
    .seq        (ia),
    .nmi_pending(nmi_pending),
    .nmi_running(nmi_running)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp)
    else begin
      nFails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst              = 1'b0;
    enableFFs         = 1'b1;
    nmi_n             = 1'b1;
    irq_n             = 1'b1;
    ia.i_flag         = 1'b1;
    ia.brk_req        = 1'b0;
    ia.instr_boundary = 1'b0;
    ia.int_ack        = 1'b0;
    ia.vector_done    = 1'b0;
    ia.rti_done       = 1'b0;
    ticks(3);

    // Reset state
    chk("rst_req",     32'(ia.int_request), 32'h0);
    chk("rst_src",     32'(ia.int_source),  32'h0);
    chk("rst_vec",     32'(ia.vector_addr), 32'hFFFC);
    chk("rst_bflag",   32'(ia.b_flag_push), 32'h0);
    chk("rst_seti",    32'(ia.set_i_flag),  32'h0);
    chk("rst_nmipend", 32'(nmi_pending),    32'h0);
    chk("rst_nmirun",  32'(nmi_running),    32'h0);

    // Reset sequence requested on the first cycle out of reset
    nrst = 1'b1;
    tick();
    chk("rseq_req", 32'(ia.int_request), 32'h1);
    chk("rseq_src", 32'(ia.int_source),  32'h0);
    chk("rseq_vec", 32'(ia.vector_addr), 32'hFFFC);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("rseq_req_drop", 32'(ia.int_request), 32'h0);
    ia.vector_done = 1'b1;
    #1;
    chk("rseq_seti", 32'(ia.set_i_flag), 32'h1);
    tick();
    ia.vector_done = 1'b0;
    #1;
    chk("rseq_seti_end", 32'(ia.set_i_flag), 32'h0);
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("rseq_no_rerequest", 32'(ia.int_request), 32'h0);

    // NMI: pending appears SYNC_STAGES+1 cycles after the pin falls
    nmi_n = 1'b0;
    ticks(2);
    chk("nmi_lat2", 32'(nmi_pending), 32'h0);
    tick();
    chk("nmi_lat3", 32'(nmi_pending), 32'h1);
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("nmi_req", 32'(ia.int_request), 32'h1);
    chk("nmi_src", 32'(ia.int_source),  32'h1);
    chk("nmi_vec", 32'(ia.vector_addr), 32'hFFFA);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("nmi_ack_pend", 32'(nmi_pending), 32'h0);
    chk("nmi_ack_run",  32'(nmi_running), 32'h1);
    ia.vector_done = 1'b1;
    tick();
    ia.vector_done = 1'b0;
    ia.rti_done = 1'b1;
    tick();
    ia.rti_done = 1'b0;
    chk("nmi_rti_run", 32'(nmi_running), 32'h0);
    nmi_n = 1'b1;
    ticks(3);

    // IRQ masked by I over three boundaries, then serviced once unmasked
    irq_n = 1'b0;
    ticks(2);
    for (int b = 0; b < 3; b++) begin
      ia.instr_boundary = 1'b1;
      tick();
      ia.instr_boundary = 1'b0;
      chk("irq_masked", 32'(ia.int_request), 32'h0);
    end
    ia.i_flag = 1'b0;
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("irq_req",   32'(ia.int_request), 32'h1);
    chk("irq_src",   32'(ia.int_source),  32'h2);
    chk("irq_vec",   32'(ia.vector_addr), 32'hFFFE);
    chk("irq_bflag", 32'(ia.b_flag_push), 32'h0);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    irq_n = 1'b1;
    ia.i_flag = 1'b1;
    ia.vector_done = 1'b1;
    tick();
    ia.vector_done = 1'b0;
    ticks(2);

    // BRK hijacked by an NMI edge while the request is outstanding
    ia.brk_req = 1'b1;
    tick();
    ia.brk_req = 1'b0;
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("brk_src",   32'(ia.int_source),  32'h3);
    chk("brk_bflag", 32'(ia.b_flag_push), 32'h1);
    chk("brk_vec",   32'(ia.vector_addr), 32'hFFFE);
    nmi_n = 1'b0;
    ticks(3);
    chk("hij_pre_src", 32'(ia.int_source), 32'h3);
    tick();
    chk("hij_src",   32'(ia.int_source),  32'h1);
    chk("hij_vec",   32'(ia.vector_addr), 32'hFFFA);
    chk("hij_bflag", 32'(ia.b_flag_push), 32'h1);
    chk("hij_req",   32'(ia.int_request), 32'h1);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("hij_ack_pend", 32'(nmi_pending), 32'h0);
    chk("hij_ack_run",  32'(nmi_running), 32'h1);
    ia.vector_done = 1'b1;
    tick();
    ia.vector_done = 1'b0;
    nmi_n = 1'b1;
    ia.rti_done = 1'b1;
    tick();
    ia.rti_done = 1'b0;
    ticks(2);
    // brk_pending must be gone: a bare boundary raises nothing
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("hij_brk_cleared", 32'(ia.int_request), 32'h0);

    // New NMI edge coincident with the ack of the previous NMI
    nmi_n = 1'b0;
    ticks(3);
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("co_src", 32'(ia.int_source), 32'h1);
    nmi_n = 1'b1;
    ticks(2);
    nmi_n = 1'b0;
    ticks(2);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("co_pend_kept", 32'(nmi_pending),    32'h1);
    chk("co_run",       32'(nmi_running),    32'h1);
    chk("co_req_drop",  32'(ia.int_request), 32'h0);
    ia.vector_done = 1'b1;
    tick();
    ia.vector_done = 1'b0;
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("co2_req", 32'(ia.int_request), 32'h1);
    chk("co2_src", 32'(ia.int_source),  32'h1);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("co2_pend", 32'(nmi_pending), 32'h0);
    ia.vector_done = 1'b1;
    tick();
    ia.vector_done = 1'b0;
    ia.rti_done = 1'b1;
    tick();
    ia.rti_done = 1'b0;
    chk("co2_run", 32'(nmi_running), 32'h0);
    nmi_n = 1'b1;
    ticks(3);

    // Enable low freezes everything, including the synchronisers
    enableFFs = 1'b0;
    nmi_n = 1'b0;
    ia.instr_boundary = 1'b1;
    ticks(5);
    ia.instr_boundary = 1'b0;
    chk("en_pend_hold", 32'(nmi_pending),    32'h0);
    chk("en_req_hold",  32'(ia.int_request), 32'h0);
    enableFFs = 1'b1;
    ticks(2);
    chk("en_lat2", 32'(nmi_pending), 32'h0);
    tick();
    chk("en_lat3", 32'(nmi_pending), 32'h1);
    ia.instr_boundary = 1'b1;
    tick();
    ia.instr_boundary = 1'b0;
    chk("en_src", 32'(ia.int_source), 32'h1);
    ia.int_ack = 1'b1;
    tick();
    ia.int_ack = 1'b0;
    chk("en_run", 32'(nmi_running), 32'h1);

    // Reset mid-operation restores reset values and re-requests the reset sequence
    nrst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(ia.int_request), 32'h0);
    chk("mid_rst_vec", 32'(ia.vector_addr), 32'hFFFC);
    chk("mid_rst_run", 32'(nmi_running),    32'h0);
    tick();
    nrst = 1'b1;
    nmi_n = 1'b1;
    tick();
    chk("mid_rst_rereq", 32'(ia.int_request), 32'h1);
    chk("mid_rst_src",   32'(ia.int_source),  32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
